// File: rtl/jtframe_shram_arb_pkg.sv
// Shared constants for the shared-RAM arbiter.
// Tie-break mode selectors for the RR parameter.
package jtframe_shram_arb_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM, read-first.
// q only updates when en is high, holding the last read.
module jtframe_ram #(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter     SIMFILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [0:2**AW-1];

  // Preload hook only; the synthesized array starts undefined.
  if (SIMFILE != "") begin : g_simfile
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= mem[addr];
  end

endmodule

// File: rtl/jtframe_shram_arb.sv
// N-channel first-come arbiter in front of one shared RAM.
// Owner holds until its cs drops; release and re-grant share an edge.
module jtframe_shram_arb
  import jtframe_shram_arb_pkg::*;
#(
  parameter int CH = 2,
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int RR = ARB_FIXED,
  parameter     SIMFILE = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    cs,
  input  logic [CH-1:0]    rnw,
  input  logic [CH*AW-1:0] addr,
  input  logic [CH*DW-1:0] din,
  output logic [DW-1:0]    dout,
  output logic [CH-1:0]    gnt,
  output logic [CH-1:0]    ok,
  output logic [CH-1:0]    busy
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0] gnt_q, gnt_nx, win;
  logic          ok_q, ok_nx;
  logic [PW-1:0] ptr, ptr_nx;
  logic [AW:0]   tag, tag_nx;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          own_rnw;
  logic          hold, access, we;

  function automatic logic [CH-1:0] rotate(
    input logic [CH-1:0] req,
    input int            start
  );
    logic [CH-1:0] g;
    int            best;
    g    = '0;
    best = CH;
    for (int j = 0; j < CH; j++) begin
      if (req[j] && ((j + CH - start) % CH) < best)
        best = (j + CH - start) % CH;
    end
    for (int j = 0; j < CH; j++)
      g[j] = req[j] && (((j + CH - start) % CH) == best);
    return g;
  endfunction

  if (CH == 1) begin : g_single
    assign win = cs;
  end else begin : g_arb
    int start;
    assign start = (RR == ARB_RR) ? (int'(ptr) + 1) % CH : 0;
    assign win   = rotate(cs, start);
  end

  // Mux is keyed on the grant so a waiting channel never reaches the RAM.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    own_rnw  = 1'b1;
    for (int k = 0; k < CH; k++) begin
      if (gnt_q[k]) begin
        ram_addr = addr[k*AW +: AW];
        ram_din  = din[k*DW +: DW];
        own_rnw  = rnw[k];
      end
    end
  end

  assign hold   = |(gnt_q & cs);
  assign access = hold & ~ok_q;
  assign we     = hold & ~own_rnw;

  always_comb begin
    gnt_nx = gnt_q;
    ok_nx  = ok_q;
    ptr_nx = ptr;
    tag_nx = tag;
    if (!hold) begin
      gnt_nx = win;
      ok_nx  = 1'b0;
      for (int k = 0; k < CH; k++)
        if (win[k]) ptr_nx = PW'(k);
    end else if (!ok_q) begin
      ok_nx  = 1'b1;
      tag_nx = {own_rnw, ram_addr};
    end else if ({own_rnw, ram_addr} != tag) begin
      ok_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      ok_q  <= 1'b0;
      ptr   <= PW'(CH - 1);
      tag   <= '0;
    end else begin
      gnt_q <= gnt_nx;
      ok_q  <= ok_nx;
      ptr   <= ptr_nx;
      tag   <= tag_nx;
    end
  end

  assign gnt  = gnt_q;
  assign ok   = gnt_q & {CH{ok_q}};
  assign busy = cs & ~ok;

  jtframe_ram #(
    .AW      (AW),
    .DW      (DW),
    .SIMFILE (SIMFILE)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (access),
    .we    (we),
    .addr  (ram_addr),
    .din   (ram_din),
    .q     (dout)
  );

endmodule
